sosanh_arbiter: RTL and testbench

SOSANH_ARBITER -- requirements
Module: sosanh_arbiter

---
 rtl/sosanh_pkg.sv | 15 +
 rtl/sosanh_arbiter_if.sv | 37 +++
 rtl/sosanh.sv | 20 ++
 rtl/sosanh_arbiter.sv | 139 +++++++++++++
 tb/tb_sosanh_arbiter.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/sosanh_pkg.sv
// Shared definitions for the sosanh comparator arbiter.
//   WIDTH_DEF : default operand width in bits
//   state_t   : arbiter FSM state encoding
package sosanh_pkg;

    localparam int unsigned WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sosanh_arbiter_if.sv
// Request/result bundle between two requesters and the comparator arbiter.
//   req0/a0/b0, req1/a1/b1 : level requests with their operands
//   gnt0/gnt1, done0/done1 : one-cycle grant / completion pulses
//   gt/lt/eq, busy         : last compare result, arbiter activity
//   master : requester side, slave : arbiter side
interface sosanh_arbiter_if
    import sosanh_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);

    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             busy;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, done0, done1, gt, lt, eq, busy
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, done0, done1, gt, lt, eq, busy
    );

endinterface

// File: rtl/sosanh.sv
// Unsigned magnitude comparator, purely combinational.
//   a, b : operands
//   x    : a > b,  y : a < b,  z : a == b
module sosanh
    import sosanh_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             x,
    output logic             y,
    output logic             z
);

    assign x = (a > b);
    assign y = (a < b);
    assign z = (a == b);

endmodule

// File: rtl/sosanh_arbiter.sv
// Round-robin arbiter sharing one comparator between two requesters.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requests/operands in; grants, done pulses, result, busy out
// All outputs are registered and change on the edge that enters a state,
// so gnt is seen in GRANT, the result from CMP on, and done in DONE.
module sosanh_arbiter
    import sosanh_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    sosanh_arbiter_if.slave    bus
);

    state_t           state_q, state_d;
    logic             winner_q, winner_d;
    logic             prefer_q, prefer_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
    logic             busy_q, busy_d;
    logic             win_c;
    logic             cmp_gt, cmp_lt, cmp_eq;

    // Single shared comparator on the latched operands
    sosanh #(.WIDTH(WIDTH)) u_cmp (
        .a (op_a_q),
        .b (op_b_q),
        .x (cmp_gt),
        .y (cmp_lt),
        .z (cmp_eq)
    );

    // A lone requester wins; on contention the preferred one wins
    assign win_c = (bus.req0 && bus.req1) ? prefer_q : bus.req1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req0 || bus.req1) state_d = GRANT;
            GRANT:   state_d = CMP;
            CMP:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values, loaded on entry to the next state
    always_comb begin
        winner_d = winner_q;
        prefer_d = prefer_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        gt_d     = gt_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        busy_d   = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    winner_d = win_c;
                    gnt0_d   = ~win_c;
                    gnt1_d   = win_c;
                    op_a_d   = win_c ? bus.a1 : bus.a0;
                    op_b_d   = win_c ? bus.b1 : bus.b0;
                end
            end
            GRANT: begin
                gt_d = cmp_gt;
                lt_d = cmp_lt;
                eq_d = cmp_eq;
            end
            CMP: begin
                done0_d = ~winner_q;
                done1_d = winner_q;
            end
            DONE: begin
                // The requester just served loses the next tie
                prefer_d = ~winner_q;
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner_q <= 1'b0;
            prefer_q <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            winner_q <= winner_d;
            prefer_q <= prefer_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign bus.gt    = gt_q;
    assign bus.lt    = lt_q;
    assign bus.eq    = eq_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_sosanh_arbiter.sv
// Directed bench for sosanh_arbiter: reset, single request, contention,
// fairness, operand change after grant and reset abort.
module tb_sosanh_arbiter;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sosanh_arbiter_if #(.WIDTH(W)) bus ();

    sosanh_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output vector order: gnt0 gnt1 done0 done1 gt lt eq busy
    task automatic expect_out(input string tag, input logic [7:0] exp);
        check(tag, 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                        bus.gt, bus.lt, bus.eq, bus.busy}), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grants and done pulses must always be mutually exclusive
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
            check("done_excl", 32'(bus.done0 & bus.done1), 32'd0);
        end
    end

    initial begin
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.a0   = '0;
        bus.b0   = '0;
        bus.a1   = '0;
        bus.b1   = '0;

        // Reset state
        #3;
        expect_out("reset_t0", 8'b0000_0000);
        tick();
        tick();
        expect_out("reset_hold", 8'b0000_0000);
        rst = 1'b0;

        // Single request: 5 > 1
        bus.req0 = 1'b1; bus.a0 = 4'd5; bus.b0 = 4'd1;
        tick(); expect_out("single_gnt", 8'b1000_0001);
        bus.req0 = 1'b0;
        tick(); expect_out("single_cmp", 8'b0000_1001);
        tick(); expect_out("single_done", 8'b0010_1001);
        tick(); expect_out("single_idle", 8'b0000_1000);
        tick(); expect_out("single_hold", 8'b0000_1000);

        // Mid-run async reset clears everything without a clock edge
        #1 rst = 1'b1;
        #1 expect_out("async_rst", 8'b0000_0000);
        #1 rst = 1'b0;

        // Contention after reset: requester 0 first (2<5), then 1 (8==8)
        bus.req0 = 1'b1; bus.a0 = 4'd2; bus.b0 = 4'd5;
        bus.req1 = 1'b1; bus.a1 = 4'd8; bus.b1 = 4'd8;
        tick(); expect_out("cont_gnt0", 8'b1000_0001);
        bus.req0 = 1'b0;
        tick(); expect_out("cont_cmp0", 8'b0000_0101);
        tick(); expect_out("cont_done0", 8'b0010_0101);
        tick(); expect_out("cont_idle", 8'b0000_0100);
        tick(); expect_out("cont_gnt1", 8'b0100_0101);
        tick(); expect_out("cont_cmp1", 8'b0000_0011);
        tick(); expect_out("cont_done1", 8'b0001_0011);
        bus.req1 = 1'b0;
        tick(); expect_out("cont_idle1", 8'b0000_0010);
        tick(); expect_out("cont_quiet", 8'b0000_0010);

        // Fairness: both held, grants alternate 0,1,0,1; 1 < 15 checks full width
        bus.a0 = 4'd7; bus.b0 = 4'd3;
        bus.a1 = 4'd1; bus.b1 = 4'd15;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            logic w;
            w = logic'(t % 2);
            tick(); check("fair_gnt", 32'({bus.gnt0, bus.gnt1}), w ? 32'd1 : 32'd2);
            tick(); check("fair_res", 32'({bus.gt, bus.lt, bus.eq}), w ? 32'd2 : 32'd4);
            tick(); check("fair_done", 32'({bus.done0, bus.done1}), w ? 32'd1 : 32'd2);
            if (t == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            tick(); check("fair_idle", 32'(bus.busy), 32'd0);
        end
        tick(); expect_out("fair_quiet", 8'b0000_0100);

        // Operand change after grant must not disturb the transaction
        bus.req1 = 1'b1; bus.a1 = 4'd3; bus.b1 = 4'd9;
        tick(); expect_out("opchg_gnt1", 8'b0100_0101);
        bus.a1 = 4'd15; bus.req1 = 1'b0;
        tick(); expect_out("opchg_cmp", 8'b0000_0101);
        tick(); expect_out("opchg_done1", 8'b0001_0101);
        tick(); expect_out("opchg_idle", 8'b0000_0100);
        tick(); expect_out("opchg_quiet", 8'b0000_0100);

        // Reset during CMP aborts without done; re-request then completes
        bus.req0 = 1'b1; bus.a0 = 4'd8; bus.b0 = 4'd8;
        tick(); expect_out("abort_gnt0", 8'b1000_0101);
        tick(); expect_out("abort_cmp", 8'b0000_0011);
        #1 rst = 1'b1;
        #1 expect_out("abort_rst", 8'b0000_0000);
        bus.req0 = 1'b0;
        #1 rst = 1'b0;
        tick(); expect_out("abort_nodone1", 8'b0000_0000);
        tick(); expect_out("abort_nodone2", 8'b0000_0000);
        tick(); expect_out("abort_nodone3", 8'b0000_0000);
        bus.req0 = 1'b1;
        tick(); expect_out("rereq_gnt0", 8'b1000_0001);
        bus.req0 = 1'b0;
        tick(); expect_out("rereq_cmp", 8'b0000_0011);
        tick(); expect_out("rereq_done0", 8'b0010_0011);
        tick(); expect_out("rereq_idle", 8'b0000_0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
